delay_ctrl: RTL

Run-time programmable sample delay for the X-engine general library: a controller that sequences a circular buffer held in a simple dual-port RAM. It applies a delay of `d` valid samples to a `DATA_W`-bit stream and accepts new delay values over a req/ack handshake. After every delay change it flushes, gating its output until the buffer holds `d` fresh samples. It sits in front of the correlator datapath wherever per-input delay is adjusted at run time.

---
 rtl/delay_ctrl_pkg.sv | 17 +
 rtl/delay_sdp_ram.sv | 48 ++++
 rtl/delay_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/delay_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : delay_ctrl_pkg                                              |
// | Brief   : Shared state encoding and constants for delay_ctrl.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package delay_ctrl_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned DELAY_MIN = 1;

endpackage : delay_ctrl_pkg
`default_nettype wire

// File: rtl/delay_sdp_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : delay_sdp_ram                                               |
// | Brief   : Simple dual-port RAM, registered read, zero when not read.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module delay_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int c_depth = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rd_raw;
    logic              r_rd_en;

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_raw <= r_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en <= 1'b0;
        end else begin
            r_rd_en <= rd_en;
        end
    end

    assign rd_data = r_rd_en ? r_rd_raw : '0;

endmodule : delay_sdp_ram
`default_nettype wire

// File: rtl/delay_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : delay_ctrl                                                  |
// | Brief   : Run-time programmable sample delay over a circular buffer.  |
// |           Define DELAY_CTRL_CNT_EN to add the reconfig_cnt output.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module delay_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 10,
    parameter int DEFAULT_DELAY = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [ADDR_W-1:0] cfg_delay,
    input  logic              cfg_req,
    output logic              cfg_ack,
    output logic              busy
`ifdef DELAY_CTRL_CNT_EN
    ,
    output logic [15:0]       reconfig_cnt
`endif
);

    localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_delay_min = ADDR_W'(DELAY_MIN);
    localparam logic [ADDR_W-1:0] c_delay_rst = ADDR_W'(DEFAULT_DELAY);

    state_t            r_state;
    logic [ADDR_W-1:0] r_d;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic              r_cfg_ack;
    logic              r_busy;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_fill_next;
    logic [ADDR_W-1:0] w_new_d;

    // A request held high through its own ack cycle must not be re-accepted.
    assign w_accept    = cfg_req & ~r_cfg_ack;
    assign w_rd_en     = in_valid & ~w_accept & (r_state == RUN);
    assign w_rd_addr   = r_wr_ptr - r_d;
    assign w_fill_next = r_fill_cnt + c_one;
    assign w_new_d     = (cfg_delay < c_delay_min) ? c_delay_min : cfg_delay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_d         <= c_delay_rst;
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_cfg_ack   <= 1'b0;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_cfg_ack   <= w_accept;
            r_out_valid <= w_rd_en;
            if (in_valid) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            // The accept-cycle sample is written but never counted.
            if (w_accept) begin
                r_d        <= w_new_d;
                r_fill_cnt <= '0;
                r_state    <= FILL;
                r_busy     <= 1'b1;
            end else if (in_valid && (r_state == FILL)) begin
                r_fill_cnt <= w_fill_next;
                if (w_fill_next == r_d) begin
                    r_state <= RUN;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    delay_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_addr (r_wr_ptr),
        .wr_data (in_data),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (out_data)
    );

    assign out_valid = r_out_valid;
    assign cfg_ack   = r_cfg_ack;
    assign busy      = r_busy;

`ifdef DELAY_CTRL_CNT_EN
    logic [15:0] r_reconfig_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reconfig_cnt <= '0;
        end else if (r_cfg_ack && (r_reconfig_cnt != 16'hFFFF)) begin
            r_reconfig_cnt <= r_reconfig_cnt + 16'd1;
        end
    end

    assign reconfig_cnt = r_reconfig_cnt;
`endif

endmodule : delay_ctrl
`default_nettype wire
